// File: rtl/uart_tx_arb.sv
// Round-robin arbiter letting NREQ byte streams share one UART transmit buffer.
// A grant ends on the packet's last byte, after MAX_BURST bytes, or after IDLE_TO idle cycles.
module uart_tx_arb #(
    parameter int NREQ      = 4,
    parameter int BITWIDTH  = 8,
    parameter int MAX_BURST = 16,
    parameter int IDLE_TO   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BITWIDTH-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [BITWIDTH-1:0]      w_data,
    output logic                     wr_uart,
    input  logic                     tx_full,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     burst_cut,
    output logic                     timeout
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      idle_q, idle_d;

    logic                sel_valid;
    logic                sel_last;
    logic [BITWIDTH-1:0] sel_data;
    logic [2*NREQ-1:0]   valid_dbl;
    logic [PW:0]         shamt;
    logic [NREQ-1:0]     rot;
    logic                win_found;
    logic [PW-1:0]       win_idx;
    logic                grant_end;

    assign busy      = (state_q == XFER);
    assign grant     = grant_q;
    assign sel_valid = |(req_valid & grant_q);
    assign sel_last  = |(req_last & grant_q);
    assign req_ready = grant_q & {NREQ{busy & ~tx_full}};
    assign wr_uart   = busy & sel_valid & ~tx_full;
    assign w_data    = wr_uart ? sel_data : '0;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) sel_data = req_data[i*BITWIDTH +: BITWIDTH];
        end
    end

    // Rotate the valid vector so bit j is requester (ptr+1+j) mod NREQ; lowest set bit wins.
    assign valid_dbl = {req_valid, req_valid};
    assign shamt     = {1'b0, ptr_q} + {{PW{1'b0}}, 1'b1};
    assign rot       = NREQ'(valid_dbl >> shamt);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr_q) + 1 + j) % NREQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        burst_cut = 1'b0;
        timeout   = 1'b0;
        grant_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = XFER;
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    gidx_d  = win_idx;
                    cnt_d   = '0;
                    idle_d  = '0;
                end
            end
            XFER: begin
                if (wr_uart) begin
                    cnt_d  = cnt_q + 8'd1;
                    idle_d = '0;
                end else if (!sel_valid) begin
                    idle_d = idle_q + 8'd1;
                end
                // A last byte landing on the burst limit is a normal packet end, not a cut.
                if (wr_uart && sel_last) begin
                    grant_end = 1'b1;
                end else if (wr_uart && (cnt_q == 8'(MAX_BURST - 1))) begin
                    grant_end = 1'b1;
                    burst_cut = 1'b1;
                end else if (!sel_valid && (idle_q == 8'(IDLE_TO - 1))) begin
                    grant_end = 1'b1;
                    timeout   = 1'b1;
                end
                if (grant_end) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PW'(NREQ - 1);
            cnt_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomised and directed bench for uart_tx_arb against a transaction-level arbiter model.
// Requesters are per-requester byte FIFOs; every cycle all outputs are compared to the model.
module tb_uart_tx_arb;
    localparam int NREQ = 4;
    localparam int BW   = 8;
    localparam int MAXB = 16;
    localparam int ITO  = 8;
    localparam int FD   = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*BW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic [BW-1:0]        w_data;
    logic                 wr_uart;
    logic                 tx_full;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 burst_cut;
    logic                 timeout;

    always #5 clk = ~clk;

    uart_tx_arb #(.NREQ(NREQ), .BITWIDTH(BW), .MAX_BURST(MAXB), .IDLE_TO(ITO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .w_data(w_data), .wr_uart(wr_uart),
        .tx_full(tx_full), .grant(grant), .busy(busy), .burst_cut(burst_cut), .timeout(timeout)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester byte FIFOs: {last, data}
    logic [BW:0] fifo [NREQ][FD];
    int head [NREQ];
    int tail [NREQ];

    int gap_pct, full_pct, full_cnt;
    bit rst_drv;

    // Reference model: current owner (-1 = none), last owner, bytes and idle cycles in this grant
    int m_owner, m_ptr, m_bytes, m_idle;

    int n_wr, n_bc, n_to, n_busy, cyc, last_wr_cyc, to_cyc;
    int last_grant, last_busy, last_wr;
    int glog [64];
    int gwr  [64];
    int ng;
    bit prev_busy;

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        oh_idx = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) oh_idx = i;
    endfunction

    function automatic bit pending();
        pending = (m_owner >= 0);
        for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) pending = 1'b1;
    endfunction

    task automatic load(input int r, input int n, input int base, input bit with_last);
        for (int k = 0; k < n; k++) begin
            fifo[r][tail[r] % FD] = {1'(with_last && (k == n - 1)), BW'(base + k)};
            tail[r]++;
        end
    endtask

    task automatic clr();
        n_wr = 0; n_bc = 0; n_to = 0; n_busy = 0; ng = 0;
        last_wr_cyc = -1; to_cyc = -1;
        for (int i = 0; i < 64; i++) begin
            glog[i] = -1;
            gwr[i]  = -1;
        end
    endtask

    task automatic drive();
        logic [NREQ-1:0]    v, l;
        logic [NREQ*BW-1:0] d;
        logic [BW:0]        e;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] != tail[i]) begin
                e = fifo[i][head[i] % FD];
                d[i*BW +: BW] = e[BW-1:0];
                l[i] = e[BW];
                v[i] = ($urandom_range(0, 99) >= gap_pct);
            end
        end
        req_valid = v;
        req_data  = d;
        req_last  = l;
        reset     = rst_drv;
        if (full_cnt > 0) begin
            tx_full = 1'b1;
            full_cnt--;
        end else begin
            tx_full = ($urandom_range(0, 99) < full_pct);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] e_grant, e_ready, hs;
        int e_wr, e_wd, e_bc, e_to, best, bestd, d;
        bit fin;
        @(negedge clk);
        drive();
        #1;
        cyc++;
        hs = req_valid & req_ready;
        fin = 1'b0;
        e_wr = 0;
        if (!reset) begin
            e_grant = '0; e_ready = '0; e_wd = 0; e_bc = 0; e_to = 0;
            if (m_owner >= 0) begin
                e_grant[m_owner] = 1'b1;
                if (!tx_full) e_ready[m_owner] = 1'b1;
                e_wr = (req_valid[m_owner] && !tx_full) ? 1 : 0;
                for (int i = 0; i < NREQ; i++)
                    if (i == m_owner && e_wr == 1) e_wd = int'(req_data[i*BW +: BW]);
                if (e_wr == 1 && req_last[m_owner]) fin = 1'b1;
                else if (e_wr == 1 && m_bytes == MAXB - 1) begin fin = 1'b1; e_bc = 1; end
                else if (!req_valid[m_owner] && m_idle == ITO - 1) begin fin = 1'b1; e_to = 1; end
            end
            chk("grant", int'(grant), int'(e_grant));
            chk("req_ready", int'(req_ready), int'(e_ready));
            chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
            chk("wr_uart", int'(wr_uart), e_wr);
            chk("w_data", int'(w_data), e_wd);
            chk("burst_cut", int'(burst_cut), e_bc);
            chk("timeout", int'(timeout), e_to);
            last_grant = int'(grant); last_busy = int'(busy); last_wr = int'(wr_uart);
            if (wr_uart) begin n_wr++; last_wr_cyc = cyc; end
            if (timeout) begin n_to++; to_cyc = cyc; end
            if (burst_cut) n_bc++;
            if (busy) n_busy++;
            if (busy && !prev_busy && ng < 64) begin
                glog[ng] = oh_idx(grant);
                gwr[ng]  = 0;
                ng++;
            end
            if (busy && wr_uart && ng > 0) gwr[ng-1]++;
            prev_busy = busy;
            for (int i = 0; i < NREQ; i++) if (hs[i] && head[i] != tail[i]) head[i]++;
        end
        @(posedge clk);
        if (reset) begin
            m_owner = -1; m_ptr = NREQ - 1; m_bytes = 0; m_idle = 0; prev_busy = 1'b0;
        end else if (m_owner < 0) begin
            best = -1; bestd = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    d = (i - m_ptr - 1 + 2 * NREQ) % NREQ;
                    if (d < bestd) begin bestd = d; best = i; end
                end
            end
            if (best >= 0) begin m_owner = best; m_bytes = 0; m_idle = 0; end
        end else if (fin) begin
            m_ptr = m_owner; m_owner = -1;
        end else if (e_wr == 1) begin
            m_bytes++; m_idle = 0;
        end else if (!req_valid[m_owner]) begin
            m_idle++;
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int c;
        c = 0;
        while (pending() && c < maxc) begin
            step();
            c++;
        end
        chk({tag, "_drained"}, int'(pending()), 0);
    endtask

    int loaded, r, len;

    initial begin
        gap_pct = 0; full_pct = 0; full_cnt = 0; rst_drv = 1'b1;
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
        m_owner = -1; m_ptr = NREQ - 1; m_bytes = 0; m_idle = 0; cyc = 0; prev_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
        clr();
        repeat (3) step();
        rst_drv = 1'b0;

        // All four requesters, 3-byte packets: order 0,1,2,3
        clr();
        for (int i = 0; i < NREQ; i++) load(i, 3, 16 * (i + 1), 1'b1);
        drain("s1", 200);
        chk("s1_writes", n_wr, 12);
        chk("s1_busy_cycles", n_busy, 12);
        chk("s1_grants", ng, 4);
        for (int i = 0; i < 4; i++) chk("s1_order", glog[i], i);

        // 20-byte packet: cut at 16, regrant for 4
        clr();
        load(2, 20, 8'h40, 1'b1);
        drain("s2", 200);
        chk("s2_writes", n_wr, 20);
        chk("s2_burst_cut", n_bc, 1);
        chk("s2_grants", ng, 2);
        chk("s2_owner0", glog[0], 2);
        chk("s2_owner1", glog[1], 2);
        chk("s2_len0", gwr[0], 16);
        chk("s2_len1", gwr[1], 4);

        // Last byte exactly on the burst limit: no cut
        clr();
        load(2, 16, 8'h80, 1'b1);
        drain("s2b", 200);
        chk("s2b_burst_cut", n_bc, 0);
        chk("s2b_grants", ng, 1);
        chk("s2b_len0", gwr[0], 16);

        // tx_full for 10 cycles mid-packet: no loss, no timeout
        clr();
        load(1, 6, 8'hA0, 1'b1);
        repeat (3) step();
        chk("s3_pre_writes", n_wr, 2);
        full_cnt = 10;
        drain("s3", 200);
        chk("s3_timeout", n_to, 0);
        chk("s3_writes", n_wr, 6);
        chk("s3_busy_cycles", n_busy, 16);
        chk("s3_grants", ng, 1);

        // Requester 3 stalls after 2 bytes: timeout IDLE_TO cycles after last write
        clr();
        load(3, 2, 8'hC0, 1'b0);
        drain("s4", 200);
        chk("s4_writes", n_wr, 2);
        chk("s4_timeout", n_to, 1);
        chk("s4_to_delay", to_cyc - last_wr_cyc, ITO);
        step();
        chk("s4_grant_after", last_grant, 0);

        // Reset during requester 0's third byte; priority returns to requester 0
        clr();
        load(1, 1, 8'h11, 1'b1);
        drain("s5a", 50);
        clr();
        load(0, 5, 8'hE0, 1'b1);
        repeat (3) step();
        chk("s5_pre_writes", n_wr, 2);
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        for (int i = 0; i < NREQ; i++) head[i] = tail[i];
        for (int i = 0; i < NREQ; i++) load(i, 1, 8'h60 + i, 1'b1);
        clr();
        step();
        chk("s5_busy_after_rst", last_busy, 0);
        chk("s5_wr_after_rst", last_wr, 0);
        chk("s5_grant_after_rst", last_grant, 0);
        drain("s5", 200);
        chk("s5_grants", ng, 4);
        chk("s5_first_owner", glog[0], 0);
        chk("s5_writes", n_wr, 4);

        // Random traffic with gaps and back-pressure
        clr();
        gap_pct = 15; full_pct = 25; loaded = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = int'($urandom_range(0, NREQ - 1));
                len = int'($urandom_range(1, 24));
                if (tail[r] - head[r] + len <= FD) begin
                    load(r, len, int'($urandom_range(0, 255)), 1'b1);
                    loaded += len;
                end
            end
            step();
        end
        gap_pct = 0; full_pct = 0;
        drain("rnd", 2000);
        chk("rnd_bytes", n_wr, loaded);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
